// File: rtl/dram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
//               Holds the two-state FSM encoding, the burst/starvation
//               counter width and the legal range of the arbiter parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_arb_pkg;

    // Width of the starvation and burst-length counters
    localparam int c_CNT_W = 8;

    // Legal range for STARVE_LIMIT and MAX_BURST
    localparam int c_PARAM_MIN = 1;
    localparam int c_PARAM_MAX = 255;

    // Arbiter state encoding
    typedef logic [0:0] state_t;
    localparam state_t c_S_NORM = 1'b0;
    localparam state_t c_S_EXT  = 1'b1;

    // True when a limit parameter fits the counter range
    function automatic logic param_in_range(input int value);
        return (value >= c_PARAM_MIN) && (value <= c_PARAM_MAX);
    endfunction

endpackage : dram_arb_pkg
`default_nettype wire

// File: rtl/dram_arb_perf.sv
`default_nettype none
// ============================================================================
// Module      : dram_arb_perf
// Description : Saturating performance counters for the data-memory arbiter:
//               core stall cycles and external grant cycles. Instantiated by
//               dram_arbiter only when DRAM_ARB_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arb_perf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_stall,
    input  logic             ext_gnt,
    output logic [WIDTH-1:0] perf_stall_cnt,
    output logic [WIDTH-1:0] perf_ext_cnt
);

    logic [WIDTH-1:0] r_stall_cnt;
    logic [WIDTH-1:0] r_ext_cnt;

    // Count stall and grant cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_ext_cnt   <= '0;
        end else begin
            if (core_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (ext_gnt && (r_ext_cnt != '1)) begin
                r_ext_cnt <= r_ext_cnt + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_ext_cnt   = r_ext_cnt;

endmodule : dram_arb_perf
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter
// Description : Shares the single-port data memory between the miniRV core
//               load/store port and one external requester. The core has
//               priority; a starvation counter forces a bounded burst of
//               external grants during which the core is stalled. External
//               read data is returned one cycle after the grant.
//               Optional feature macro: DRAM_ARB_PERF_EN (perf counters).
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic        clk,
    input  logic        rst,
    // core load/store port
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdin,
    output logic [31:0] core_rd,
    output logic        core_stall,
    // external requester
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    // memory port
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdin,
    output logic        dram_we,
    input  logic [31:0] dram_rd,
    // performance counters
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_ext_cnt
);

    // Terminal counter values: the transition fires on the cycle the counter
    // already holds LIMIT-1, so the counted cycle itself is included.
    localparam logic [c_CNT_W-1:0] c_STARVE_LAST = c_CNT_W'(STARVE_LIMIT - 1);
    localparam logic [c_CNT_W-1:0] c_BURST_LAST  = c_CNT_W'(MAX_BURST - 1);

    if (!param_in_range(STARVE_LIMIT)) begin : g_bad_starve_limit
        $error("dram_arbiter: STARVE_LIMIT out of range 1..255");
    end
    if (!param_in_range(MAX_BURST)) begin : g_bad_max_burst
        $error("dram_arbiter: MAX_BURST out of range 1..255");
    end

    state_t             r_state;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic [c_CNT_W-1:0] r_run_cnt;
    logic               r_ext_rvalid;
    logic [31:0]        r_ext_rdata;
    logic               w_ext_gnt;

    // Grant is combinational from the registered state: the core wins in
    // normal mode, the external side wins unconditionally inside a burst.
    always_comb begin
        w_ext_gnt = 1'b0;
        if (r_state == c_S_EXT) begin
            w_ext_gnt = ext_req;
        end else begin
            w_ext_gnt = ext_req & ~core_req;
        end
    end

    // Arbiter FSM: count lost external cycles, then run a bounded burst
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_NORM;
            r_starve_cnt <= '0;
            r_run_cnt    <= '0;
        end else begin
            case (r_state)
                c_S_NORM: begin
                    r_run_cnt <= '0;
                    if (ext_req && core_req) begin
                        // Core still wins this cycle even when the limit is hit
                        if (r_starve_cnt == c_STARVE_LAST) begin
                            r_state      <= c_S_EXT;
                            r_starve_cnt <= '0;
                        end else begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else begin
                        // Either the external side was granted or is idle
                        r_starve_cnt <= '0;
                    end
                end
                c_S_EXT: begin
                    r_starve_cnt <= '0;
                    if (!ext_req) begin
                        r_state   <= c_S_NORM;
                        r_run_cnt <= '0;
                    end else if (r_run_cnt == c_BURST_LAST) begin
                        r_state   <= c_S_NORM;
                        r_run_cnt <= '0;
                    end else begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= c_S_NORM;
                    r_starve_cnt <= '0;
                    r_run_cnt    <= '0;
                end
            endcase
        end
    end

    // Capture external read data one cycle after a read grant; data holds
    // otherwise so the requester may sample it late.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_rvalid <= 1'b0;
            r_ext_rdata  <= '0;
        end else begin
            r_ext_rvalid <= w_ext_gnt & ~ext_we;
            if (w_ext_gnt && !ext_we) begin
                r_ext_rdata <= dram_rd;
            end
        end
    end

    // Memory mux: the granted external access overrides the core
    always_comb begin
        dram_addr = core_addr;
        dram_wdin = core_wdin;
        dram_we   = core_we & core_req;
        if (w_ext_gnt) begin
            dram_addr = ext_addr;
            dram_wdin = ext_wdata;
            dram_we   = ext_we;
        end
    end

    assign ext_gnt    = w_ext_gnt;
    assign core_stall = core_req & w_ext_gnt;
    assign core_rd    = dram_rd;
    assign ext_rvalid = r_ext_rvalid;
    assign ext_rdata  = r_ext_rdata;

`ifdef DRAM_ARB_PERF_EN
    dram_arb_perf #(
        .WIDTH(32)
    ) u_perf (
        .clk            (clk),
        .rst            (rst),
        .core_stall     (core_stall),
        .ext_gnt        (w_ext_gnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_ext_cnt   (perf_ext_cnt)
    );
`else
    assign perf_stall_cnt = '0;
    assign perf_ext_cnt   = '0;
`endif

endmodule : dram_arbiter
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_arbiter
// Description : Scoreboard bench for dram_arbiter (default parameters).
//               Stimulus pushes the hand-derived expected response of each
//               cycle; a monitor on the falling edge pops and compares.
//               Perf counter checks are active under DRAM_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_arbiter;

    logic        clk;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdin, core_rd;
    logic        core_stall;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic [31:0] dram_addr, dram_wdin, dram_rd;
    logic        dram_we;
    logic [31:0] perf_stall_cnt, perf_ext_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        gnt;
        logic        stall;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdin;
        logic [31:0] crd;
        logic        rvalid;
        logic [31:0] rdata;
        logic        chk_perf;
        logic [31:0] pstall;
        logic [31:0] pext;
    } exp_t;

    exp_t sb_q[$];

    dram_arbiter #(
        .STARVE_LIMIT(4),
        .MAX_BURST   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .core_req       (core_req),
        .core_we        (core_we),
        .core_addr      (core_addr),
        .core_wdin      (core_wdin),
        .core_rd        (core_rd),
        .core_stall     (core_stall),
        .ext_req        (ext_req),
        .ext_we         (ext_we),
        .ext_addr       (ext_addr),
        .ext_wdata      (ext_wdata),
        .ext_gnt        (ext_gnt),
        .ext_rvalid     (ext_rvalid),
        .ext_rdata      (ext_rdata),
        .dram_addr      (dram_addr),
        .dram_wdin      (dram_wdin),
        .dram_we        (dram_we),
        .dram_rd        (dram_rd),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_ext_cnt   (perf_ext_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare whatever the stimulus expected for this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp(e.name, "ext_gnt",    {31'd0, ext_gnt},    {31'd0, e.gnt});
                cmp(e.name, "core_stall", {31'd0, core_stall}, {31'd0, e.stall});
                cmp(e.name, "dram_we",    {31'd0, dram_we},    {31'd0, e.we});
                cmp(e.name, "dram_addr",  dram_addr,           e.addr);
                cmp(e.name, "dram_wdin",  dram_wdin,           e.wdin);
                cmp(e.name, "core_rd",    core_rd,             e.crd);
                cmp(e.name, "ext_rvalid", {31'd0, ext_rvalid}, {31'd0, e.rvalid});
                cmp(e.name, "ext_rdata",  ext_rdata,           e.rdata);
                if (e.chk_perf) begin
                    cmp(e.name, "perf_stall_cnt", perf_stall_cnt, e.pstall);
                    cmp(e.name, "perf_ext_cnt",   perf_ext_cnt,   e.pext);
                end
            end
        end
    end

    // Apply one cycle of inputs just after the rising edge
    task automatic drive(input logic r, input logic creq, input logic cwe,
                         input logic [31:0] caddr, input logic [31:0] cwdin,
                         input logic ereq, input logic ewe,
                         input logic [31:0] eaddr, input logic [31:0] ewd,
                         input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst       = r;
        core_req  = creq;
        core_we   = cwe;
        core_addr = caddr;
        core_wdin = cwdin;
        ext_req   = ereq;
        ext_we    = ewe;
        ext_addr  = eaddr;
        ext_wdata = ewd;
        dram_rd   = rd;
    endtask

    task automatic expect_cyc(input string nm, input logic g, input logic st, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdin,
                              input logic [31:0] crd, input logic rv, input logic [31:0] rdv,
                              input logic cp, input logic [31:0] ps, input logic [31:0] pe);
        exp_t e;
        e.name = nm; e.gnt = g; e.stall = st; e.we = we; e.addr = addr; e.wdin = wdin;
        e.crd = crd; e.rvalid = rv; e.rdata = rdv;
`ifdef DRAM_ARB_PERF_EN
        e.chk_perf = cp;
`else
        e.chk_perf = 1'b1;
        if (cp) begin
            e.chk_perf = 1'b1;
        end
`endif
        e.pstall = ps; e.pext = pe;
`ifndef DRAM_ARB_PERF_EN
        // Without the feature both counters are tied to zero
        e.pstall = 32'd0;
        e.pext   = 32'd0;
`endif
        sb_q.push_back(e);
    endtask

    // Expected grant pattern of the scenario, bit j = cycle j
    logic [28:0] gnt_tab;
    logic        prev_gnt;
    logic [31:0] exp_rdata;
    logic        rst_j;
    logic        g;

    initial begin
        rst = 1'b1; core_req = 0; core_we = 0; core_addr = 0; core_wdin = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; dram_rd = 0;

        // Reset: second reset cycle shows cleared registers
        drive(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        drive(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        expect_cyc("reset", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1, 32'd0, 32'd0);

        // Core-only store
        drive(0, 1, 1, 32'h10, 32'hA5, 0, 0, 32'h0, 32'h0, 32'h0);
        expect_cyc("core_store", 0, 0, 1, 32'h10, 32'hA5, 32'h0, 0, 32'h0, 0, 0, 0);

        // External-only read, then its response
        drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0, 32'h1234);
        expect_cyc("ext_read", 1, 0, 0, 32'h20, 32'h0, 32'h1234, 0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        expect_cyc("ext_rresp", 0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 32'h1234, 0, 0, 0);

        // External write: no read response, data held
        drive(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h24, 32'hCAFE, 32'h0);
        expect_cyc("ext_write", 1, 0, 1, 32'h24, 32'hCAFE, 32'h0, 0, 32'h1234, 0, 0, 0);

        // Core load, zero-latency read data
        drive(0, 1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0, 32'h55);
        expect_cyc("core_load", 0, 0, 0, 32'h30, 32'h0, 32'h55, 0, 32'h1234, 0, 0, 0);

        // Reset before the starvation scenario
        drive(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        expect_cyc("reset2", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h1234, 0, 0, 0);

        // Starvation, burst repeat, early exit (ext_req low at 19),
        // return to normal, reset on 2nd forced grant (cycle 25)
        gnt_tab   = 29'b000_11_0000_0_111_0000_11111111_0000;
        prev_gnt  = 1'b0;
        exp_rdata = 32'h0;
        for (int j = 0; j < 29; j++) begin
            logic ereq;
            string nm;
            ereq  = (j != 19);
            rst_j = (j == 25);
            g     = gnt_tab[j];
            nm    = $sformatf("scen%0d", j);
            drive(rst_j, 1, 0, 32'h40, 32'h77, ereq, 0, 32'h80, 32'h99, 32'h1000 + 32'(j));
            if (j == 12) begin
                expect_cyc(nm, g, g, 0, g ? 32'h80 : 32'h40, g ? 32'h99 : 32'h77,
                           32'h1000 + 32'(j), prev_gnt, exp_rdata, 1, 32'd8, 32'd8);
            end else if (j == 26) begin
                expect_cyc(nm, g, g, 0, g ? 32'h80 : 32'h40, g ? 32'h99 : 32'h77,
                           32'h1000 + 32'(j), prev_gnt, exp_rdata, 1, 32'd0, 32'd0);
            end else begin
                expect_cyc(nm, g, g, 0, g ? 32'h80 : 32'h40, g ? 32'h99 : 32'h77,
                           32'h1000 + 32'(j), prev_gnt, exp_rdata, 0, 0, 0);
            end
            // Registered response visible in the following cycle
            if (rst_j) begin
                prev_gnt  = 1'b0;
                exp_rdata = 32'h0;
            end else begin
                prev_gnt = g;
                if (g) begin
                    exp_rdata = 32'h1000 + 32'(j);
                end
            end
        end

        // Drain the scoreboard with a bounded wait
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dram_arbiter
`default_nettype wire
